adder_3bits_accum: RTL and testbench
====================================

// Module: adder_3bits_accum
// PURPOSE
//   Downstream consumer of the 3-bit adder result {co,sum}. Accepts one 4-bit
//   result per beat over a valid/ready handshake and accumulates N_SAMPLES
//   beats into a wide register. Presents the block total, with a sticky
//   overflow flag, on a valid/ready output. Sits between the combinational
//   adder and any result sink (display, checker, bus).
// PARAMETERS
//   ACC_W      8   accumulator width in bits; legal range ACC_W >= 4
//   N_SAMPLES  4   beats per block; legal range N_SAMPLES >= 1
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   flush      in   1        synchronous abort: discards the partial or held block
//   in_valid   in   1        in_sum/in_co valid
//   in_ready   out  1        block can accept a beat
//   in_sum     in   3        adder sum
//   in_co      in   1        adder carry-out
//   out_valid  out  1        block result valid
//   out_ready  in   1        sink accepts the result
//   out_acc    out  ACC_W    block total modulo 2^ACC_W
//   out_ovf    out  1        total exceeded 2^ACC_W - 1 during this block
// BEHAVIOUR
//   - Beat value is {in_co,in_sum} (0..15), zero-extended to ACC_W.
//   - A beat is accepted when in_valid && in_ready; a result is taken when
//     out_valid && out_ready.
//   - Reset (asynchronous): state=ACCUM, acc=0, cnt=0, ovf=0, in_ready=1,
//     out_valid=0, out_acc=0, out_ovf=0.
//   - FSM, 2 states:
//     ACCUM: in_ready=1, out_valid=0. On each accepted beat: acc<=acc+val,
//            ovf<=ovf|carry-out of the ACC_W add, cnt<=cnt+1. When the
//            accepted beat is number N_SAMPLES (cnt==N_SAMPLES-1), go to DONE.
//     DONE:  in_ready=0, out_valid=1. out_acc and out_ovf are driven from the
//            acc/ovf registers and stay stable until the result is taken.
//            On take: acc=0, cnt=0, ovf=0, next state ACCUM.
//   - Latency: out_valid rises on the cycle after the last beat is accepted.
//   - No same-cycle pass-through from take to a new beat: in_ready rises on
//     the cycle after the take (one bubble per block).
//   - Wrap-around: acc wraps modulo 2^ACC_W and out_ovf is sticky until the
//     result is taken.
//   - flush: acc=0, cnt=0, ovf=0, next state ACCUM, effective next cycle.
//     flush has priority over a same-cycle accepted beat (the beat is dropped)
//     and over a same-cycle take (the result is discarded).
//   - in_valid while in_ready=0 is ignored; the source must hold the data.
//   - N_SAMPLES=1: every accepted beat produces a result.
//   - Counter width: $clog2(N_SAMPLES+1).
// STRUCTURE
//   - Shared package adder_3bits_pkg holds:
//     - VAL_W=4 (width of {co,sum})
//     - the FSM state encoding: ST_ACCUM=1'b0, ST_DONE=1'b1
//   - Single flat module; no sub-module is needed.
//   - The ACC_W add is an inline expression, one bit wider to capture carry.
// TESTING (ACC_W=8, N_SAMPLES=4 unless stated)
//   1. Beats {co,sum} = 0_010, 1_000, 0_111, 0_001, back-to-back
//      -> out_acc=8'h12, out_ovf=0, out_valid on the cycle after beat 4.
//   2. Same block with out_ready low for 3 cycles -> out_valid and
//      out_acc=8'h12 held and in_ready=0 for those 3 cycles; in_ready=1 the
//      cycle after the take.
//   3. ACC_W=5, four beats of 1_111 (15) -> out_acc=5'd28 (60 mod 32),
//      out_ovf=1; next block 4x 0_001 -> out_acc=4, out_ovf=0.
//   4. Two beats of 0_011, then flush asserted together with a third valid
//      beat -> that beat is dropped; the next 4 beats of 0_001 -> out_acc=4.
//   5. rst pulsed asynchronously mid-block after 2 beats -> all outputs 0 and
//      in_ready=1 immediately; the next 4 beats of 0_010 -> out_acc=8.
//   6. in_valid held high while in DONE -> no beat is accepted and acc is
//      unchanged until the take.

Source files
------------

// File: rtl/adder_3bits_pkg.sv
// Shared definitions for the 3-bit adder result path: beat width and FSM encoding.
package adder_3bits_pkg;

   // Width of one adder result beat {co,sum}
   localparam int VAL_W = 4;

   // Accumulator FSM encoding
   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

endpackage : adder_3bits_pkg

// File: rtl/adder_3bits_accum_if.sv
// Handshake bundle between an adder result source and the block accumulator.
interface adder_3bits_accum_if #(
   parameter int ACC_W = 8
);
   import adder_3bits_pkg::*;

   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_sum;
   logic               in_co;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_W-1:0]   out_acc;
   logic               out_ovf;

   // Source/sink side: drives beats and flush, accepts results
   modport master (
      output flush, in_valid, in_sum, in_co, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf
   );

   // Accumulator side
   modport slave (
      input  flush, in_valid, in_sum, in_co, out_ready,
      output in_ready, out_valid, out_acc, out_ovf
   );

endinterface : adder_3bits_accum_if

// File: rtl/adder_3bits_accum.sv
// Accumulates N_SAMPLES adder results {co,sum} per block and presents the
// block total plus a sticky overflow flag on a valid/ready output.
module adder_3bits_accum
   import adder_3bits_pkg::*;
#(
   parameter int ACC_W     = 8,
   parameter int N_SAMPLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_3bits_accum_if.slave   bus
);

   localparam int CNT_W = $clog2(N_SAMPLES + 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_beat;
   logic               w_take;
   logic               w_last;
   logic [ACC_W-1:0]   w_val;
   logic [ACC_W:0]     w_sum;

   // Handshake qualifiers; the ACC_W add is one bit wider so its carry feeds ovf
   assign w_beat = bus.in_valid && w_in_ready;
   assign w_take = w_out_valid && bus.out_ready;
   assign w_last = (r_cnt == CNT_W'(N_SAMPLES - 1));
   assign w_val  = ACC_W'({bus.in_co, bus.in_sum});
   assign w_sum  = {1'b0, r_acc} + {1'b0, w_val};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; flush overrides both the last beat and a take
   always_comb begin
      w_state_next = r_state;
      if (bus.flush) begin
         w_state_next = ST_ACCUM;
      end else begin
         case (r_state)
            ST_ACCUM: if (w_beat && w_last) w_state_next = ST_DONE;
            ST_DONE:  if (w_take)           w_state_next = ST_ACCUM;
            default:                        w_state_next = ST_ACCUM;
         endcase
      end
   end

   // Output decode: ready only while accumulating, valid only while holding a result
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         ST_ACCUM: w_in_ready  = 1'b1;
         ST_DONE:  w_out_valid = 1'b1;
         default:  w_in_ready  = 1'b1;
      endcase
   end

   // Accumulator, beat counter and sticky overflow; cleared by flush or take
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (bus.flush) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_beat) begin
         r_acc <= w_sum[ACC_W-1:0];
         r_ovf <= r_ovf | w_sum[ACC_W];
         r_cnt <= r_cnt + 1'b1;
      end else if (w_take) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_acc   = r_acc;
   assign bus.out_ovf   = r_ovf;

endmodule : adder_3bits_accum

// File: tb/tb_adder_3bits_accum.sv
// Scoreboard bench: directed blocks on an 8-bit and a 5-bit accumulator.
module tb_adder_3bits_accum;

   logic clk;
   logic rst;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] exp8_q[$];   // {ovf, acc[7:0]}
   logic [5:0] exp5_q[$];   // {ovf, acc[4:0]}

   adder_3bits_accum_if #(.ACC_W(8)) if8 ();
   adder_3bits_accum_if #(.ACC_W(5)) if5 ();

   adder_3bits_accum #(.ACC_W(8), .N_SAMPLES(4)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8.slave)
   );

   adder_3bits_accum #(.ACC_W(5), .N_SAMPLES(4)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (if5.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end else begin
         $display("[TB] ok   %s = %h", name, got);
      end
   endtask

   // Monitor for the 8-bit instance: every take is compared against the queue head
   always @(negedge clk) begin
      if (!rst && if8.out_valid && if8.out_ready) begin
         if (exp8_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL take8: unexpected result acc=%h ovf=%b", if8.out_acc, if8.out_ovf);
         end else begin
            check("take8", {7'd0, if8.out_ovf, if8.out_acc}, {7'd0, exp8_q.pop_front()});
         end
      end
   end

   // Monitor for the 5-bit instance
   always @(negedge clk) begin
      if (!rst && if5.out_valid && if5.out_ready) begin
         if (exp5_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL take5: unexpected result acc=%h ovf=%b", if5.out_acc, if5.out_ovf);
         end else begin
            check("take5", {10'd0, if5.out_ovf, if5.out_acc}, {10'd0, exp5_q.pop_front()});
         end
      end
   end

   // Offer one beat to dut8 and return #1 after the edge that accepted it
   task automatic beat8(input logic [3:0] v);
      bit ok;
      ok = 0;
      if8.in_valid = 1'b1;
      {if8.in_co, if8.in_sum} = v;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (if8.in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat8: in_ready timeout");
      end
      @(posedge clk);
      #1;
      if8.in_valid = 1'b0;
   endtask

   task automatic beat5(input logic [3:0] v);
      bit ok;
      ok = 0;
      if5.in_valid = 1'b1;
      {if5.in_co, if5.in_sum} = v;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (if5.in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat5: in_ready timeout");
      end
      @(posedge clk);
      #1;
      if5.in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      if8.flush = 0; if8.in_valid = 0; if8.in_sum = 0; if8.in_co = 0; if8.out_ready = 1;
      if5.flush = 0; if5.in_valid = 0; if5.in_sum = 0; if5.in_co = 0; if5.out_ready = 1;
      #3;
      check("rst_in_ready",  {15'd0, if8.in_ready},  16'd1);
      check("rst_out_valid", {15'd0, if8.out_valid}, 16'd0);
      check("rst_out_acc",   {8'd0, if8.out_acc},    16'd0);
      check("rst_out_ovf",   {15'd0, if8.out_ovf},   16'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: back-to-back block, result visible the cycle after beat 4
      exp8_q.push_back({1'b0, 8'h12});
      beat8(4'b0010); beat8(4'b1000); beat8(4'b0111); beat8(4'b0001);
      @(negedge clk);
      check("lat_out_valid", {15'd0, if8.out_valid}, 16'd1);
      @(posedge clk); #1;

      // 2 + 6: result held with out_ready low while in_valid stays asserted
      if8.out_ready = 1'b0;
      exp8_q.push_back({1'b0, 8'h12});
      beat8(4'b0010); beat8(4'b1000); beat8(4'b0111); beat8(4'b0001);
      if8.in_valid = 1'b1;
      {if8.in_co, if8.in_sum} = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_out_valid", {15'd0, if8.out_valid}, 16'd1);
         check("hold_out_acc",   {8'd0, if8.out_acc},    16'h12);
         check("hold_in_ready",  {15'd0, if8.in_ready},  16'd0);
      end
      @(posedge clk); #1;
      if8.in_valid  = 1'b0;
      if8.out_ready = 1'b1;
      @(posedge clk);          // take edge
      @(negedge clk);
      check("bubble_in_ready", {15'd0, if8.in_ready}, 16'd1);
      @(posedge clk); #1;

      // 3: 5-bit wrap with sticky overflow, then a clean block
      exp5_q.push_back({1'b1, 5'd28});
      beat5(4'b1111); beat5(4'b1111); beat5(4'b1111); beat5(4'b1111);
      exp5_q.push_back({1'b0, 5'd4});
      beat5(4'b0001); beat5(4'b0001); beat5(4'b0001); beat5(4'b0001);

      // 4: flush drops the partial block and a same-cycle beat
      beat8(4'b0011); beat8(4'b0011);
      if8.in_valid = 1'b1;
      {if8.in_co, if8.in_sum} = 4'b0011;
      if8.flush = 1'b1;
      @(posedge clk); #1;
      if8.flush = 1'b0;
      if8.in_valid = 1'b0;
      exp8_q.push_back({1'b0, 8'h04});
      beat8(4'b0001); beat8(4'b0001); beat8(4'b0001); beat8(4'b0001);

      // 5: asynchronous reset mid-block, checked before the next edge
      @(posedge clk); #1;
      beat8(4'b0010); beat8(4'b0010);
      #2 rst = 1'b1;
      #1;
      check("arst_in_ready",  {15'd0, if8.in_ready},  16'd1);
      check("arst_out_valid", {15'd0, if8.out_valid}, 16'd0);
      check("arst_out_acc",   {8'd0, if8.out_acc},    16'd0);
      check("arst_out_ovf",   {15'd0, if8.out_ovf},   16'd0);
      rst = 1'b0;
      exp8_q.push_back({1'b0, 8'h08});
      beat8(4'b0010); beat8(4'b0010); beat8(4'b0010); beat8(4'b0010);

      // Drain: every pushed result must have been taken
      for (int i = 0; i < 20; i++) begin
         if (exp8_q.size() == 0 && exp5_q.size() == 0) break;
         @(posedge clk);
      end
      #1;
      check("drain8", 16'(exp8_q.size()), 16'd0);
      check("drain5", 16'(exp5_q.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_adder_3bits_accum
